// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between I-cache fills and D-cache fills/write-throughs.
// Fill done 9+MEM_LAT cycles after grant request, write done after 2; losers wait with stall held high.
module mem_arbiter #(
  parameter int  WORDS_PER_BLOCK = 8,
  parameter int  MEM_LAT         = 4,
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_miss,
  input  logic [15:0]      i_addr,
  input  logic             d_miss,
  input  logic [15:0]      d_addr,
  input  logic             d_wr,
  input  logic [15:0]      d_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_valid,
  output logic [15:0]      mem_addr,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_wdata,
  output logic [15:0]      fill_data,
  output logic [OFF_W-1:0] fill_offset,
  output logic             i_fill_we,
  output logic             d_fill_we,
  output logic             i_done,
  output logic             d_done,
  output logic             i_stall,
  output logic             d_stall,
  output logic             busy
);

  localparam int          ISS_W    = OFF_W + 1;
  localparam int          DRN_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_WRITE, S_FILL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ISS_W-1:0]   iss_q, iss_d;
  logic [OFF_W-1:0]   rcv_q, rcv_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               own_d_q, own_d_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               i_skip_q, i_skip_d;

  logic               grant_wr, grant_i, grant_d;
  logic               issuing, fill_vld, done_vld;

  // i_skip lets a passed-over I request beat the next D fill (writes still win).
  assign grant_wr = d_wr;
  assign grant_i  = ~d_wr & i_miss & (i_skip_q | ~d_miss);
  assign grant_d  = ~d_wr & ~grant_i & d_miss;

  always_comb begin
    state_d  = state_q;
    iss_d    = iss_q;
    rcv_d    = rcv_q;
    drn_d    = drn_q;
    own_d_d  = own_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    i_skip_d = i_skip_q;
    case (state_q)
      S_DRAIN: begin
        if (drn_q == DRN_W'(MEM_LAT - 1)) begin
          drn_d   = '0;
          state_d = S_IDLE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (grant_wr | grant_i | grant_d) begin
          own_d_d  = ~grant_i;
          addr_d   = grant_i ? i_addr : d_addr;
          wdata_d  = d_wdata;
          iss_d    = '0;
          rcv_d    = '0;
          i_skip_d = grant_i ? 1'b0 : (i_skip_q | i_miss);
          state_d  = grant_wr ? S_WRITE : S_FILL;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_FILL: begin
        if (iss_q != ISS_W'(WORDS_PER_BLOCK)) iss_d = iss_q + 1'b1;
        if (mem_valid) begin
          rcv_d = rcv_q + 1'b1;
          if (rcv_q == OFF_W'(WORDS_PER_BLOCK - 1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DRAIN;
      iss_q    <= '0;
      rcv_q    <= '0;
      drn_q    <= '0;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_skip_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      iss_q    <= iss_d;
      rcv_q    <= rcv_d;
      drn_q    <= drn_d;
      own_d_q  <= own_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      i_skip_q <= i_skip_d;
    end
  end

  // Gating with rst makes an abort take effect in the very cycle reset is raised.
  assign issuing  = (state_q == S_FILL) && (iss_q != ISS_W'(WORDS_PER_BLOCK));
  assign fill_vld = ~rst & (state_q == S_FILL) & mem_valid;
  assign done_vld = ~rst & (state_q == S_DONE);

  assign mem_en    = ~rst & ((state_q == S_WRITE) | issuing);
  assign mem_wr    = ~rst & (state_q == S_WRITE);
  assign mem_addr  = !mem_en ? 16'h0000 :
                     (state_q == S_WRITE) ? addr_q :
                     (addr_q & BLK_MASK) + 16'({iss_q[OFF_W-1:0], 1'b0});
  assign mem_wdata = wdata_q;

  assign fill_data   = mem_rdata;
  assign fill_offset = rcv_q;
  assign i_fill_we   = fill_vld & ~own_d_q;
  assign d_fill_we   = fill_vld & own_d_q;
  assign i_done      = done_vld & ~own_d_q;
  assign d_done      = done_vld & own_d_q;

  assign i_stall = i_miss & ~i_done;
  assign d_stall = (d_miss | d_wr) & ~d_done;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle, pipelined main memory between the I-cache miss path (instruction fetch) and the D-cache miss/write-through path.
- Sequences 8-word block fills and single-word writes, and steers returning words to the correct cache.
- Generates stall signals that hold the PC register and pipeline while a request is outstanding.
- Sits between both cache controllers and the memory4c-style memory model.

Parameters:
WORDS_PER_BLOCK, 8, words per cache block; power of 2; OFF_W = log2(WORDS_PER_BLOCK)
MEM_LAT, 4, cycles from read issue to mem_valid for that word; memory is pipelined, one issue per cycle

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_miss  in  1  I-cache block-fill request; held until i_done
i_addr  in  16  I-side byte address of missing word
d_miss  in  1  D-cache block-fill request; held until d_done
d_addr  in  16  D-side byte address (fill or write)
d_wr  in  1  D-side single-word write-through request; held until d_done
d_wdata  in  16  write data for d_wr
mem_rdata  in  16  memory read data
mem_valid  in  1  mem_rdata valid this cycle
mem_addr  out  16  memory byte address
mem_en  out  1  memory access enable
mem_wr  out  1  1 = write, 0 = read
mem_wdata  out  16  memory write data
fill_data  out  16  word being filled (= mem_rdata)
fill_offset  out  OFF_W  word index within block of fill_data
i_fill_we  out  1  write fill_data into I-cache this cycle
d_fill_we  out  1  write fill_data into D-cache this cycle
i_done  out  1  one-cycle pulse: I request complete
d_done  out  1  one-cycle pulse: D request (fill or write) complete
i_stall  out  1  i_miss & ~i_done (combinational)
d_stall  out  1  (d_miss | d_wr) & ~d_done (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset: state = DRAIN; counters cleared; all registered outputs 0; mem_addr = 0.
- Reset mid-operation aborts immediately; no done pulse is produced for the aborted request.
- FSM states: DRAIN, IDLE, WRITE, FILL, DONE.
- DRAIN: count MEM_LAT cycles, then go to IDLE.
  - Any mem_valid is ignored, so stale in-flight reads never reach a cache.
  - No grants are made during DRAIN.
- IDLE arbitration priority: d_wr > d_miss > i_miss.
- Anti-starvation flag i_skip:
  - Set when i_miss is pending but D is granted.
  - While i_skip = 1, i_miss beats d_miss (d_wr still wins).
  - Cleared on any I grant.
- Grant actions:
  - Latch owner (I/D), base = addr & ~(2*WORDS_PER_BLOCK-1), and write data.
  - Go to WRITE (d_wr) or FILL.
- WRITE (1 cycle): mem_en = 1, mem_wr = 1, mem_addr = latched d_addr, mem_wdata = latched d_wdata; then go to DONE.
- FILL:
  - Issue counter iss runs 0..WORDS_PER_BLOCK-1, one per cycle: mem_en = 1, mem_wr = 0, mem_addr = base + 2*iss.
  - After the last issue, mem_en = 0.
  - Receive counter rcv increments on each mem_valid.
  - When mem_valid: fill_data = mem_rdata, fill_offset = rcv, and owner's fill_we = 1.
  - mem_valid is counted only in FILL; elsewhere it is ignored.
  - Last word received (rcv = WORDS_PER_BLOCK-1 with mem_valid) -> DONE.
- DONE (1 cycle): pulse owner's done, then go to IDLE.
  - The requester drops its request in the cycle after done.
  - Re-arbitration happens in that IDLE cycle.
- Requester deasserting mid-operation: ignored; the operation completes and done still pulses.
- Address arithmetic is 16-bit modulo; base + 2*iss never wraps within a block because base is aligned.
- A request arriving while busy: waits, stall stays high.
- Latency, request in cycle 0: FILL issues cycles 1..8, data cycles 1+MEM_LAT..8+MEM_LAT, done at cycle 9+MEM_LAT. A write's done is at cycle 2.

Test Plan:
- I fill, MEM_LAT=4:
  - Stimulus: rst high 1 cycle, wait 4 (DRAIN), i_miss with i_addr=0x0036.
  - Required: mem_addr 0x0030,0x0032..0x003E; i_fill_we with offsets 0..7; i_done one cycle; i_stall high until the i_done cycle.
- Simultaneous d_miss (0x1000) and i_miss (0x0100):
  - Required: D fill first, then I fill.
  - With d_miss re-asserted at D's done, I still wins (i_skip).
- d_wr 0x2002 / 0xBEEF concurrent with i_miss:
  - Required: one write cycle (mem_wr=1, addr 0x2002, data 0xBEEF), d_done at cycle 2, then I fill.
- rst asserted during FILL after 3 words with stale mem_valid continuing:
  - Required: no fill_we and no done for 4 cycles.
  - Next grant occurs only after DRAIN.
- Spurious mem_valid in IDLE:
  - Required: no fill_we; rcv unchanged.
- Requester drops i_miss mid-fill:
  - Required: all 8 words still delivered and i_done pulses.
